// File: rtl/rrv64_clkgate_pkg.sv
// Shared types and default widths for the L1D clock-gate enable controller.
package rrv64_clkgate_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_GATED = 2'd1,
    ST_WAKE  = 2'd2
  } state_e;

  localparam int IDLE_W_DEF = 8;
  localparam int STAT_W_DEF = 16;

endpackage

// File: rtl/rrv64_clkgate_ctrl.sv
// Idle-count / wake FSM driving the enable and scan-enable of one L1D clock-gate cell.
// Enable drops 1 cycle after the Nth idle cycle; ready follows enable by WAKE_LAT cycles; no backpressure.
module rrv64_clkgate_ctrl
  import rrv64_clkgate_pkg::*;
#(
  parameter int IDLE_W   = IDLE_W_DEF,
  parameter int WAKE_LAT = 2,
  parameter int STAT_W   = STAT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              busy_i,
  input  logic              wake_req_i,
  input  logic              force_on_i,
  input  logic [IDLE_W-1:0] idle_thresh_i,
  input  logic              scan_en_i,
  output logic              clk_enable_o,
  output logic              clk_senable_o,
  output logic              ready_o,
  output logic              gated_o,
  output logic [STAT_W-1:0] gate_cnt_o
);

  localparam int WK_W = (WAKE_LAT > 1) ? $clog2(WAKE_LAT) : 1;
  localparam logic [WK_W-1:0] WAKE_LAST = (WAKE_LAT > 0) ? WK_W'(WAKE_LAT - 1) : '0;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [IDLE_W-1:0]   r_idle_cnt;
  logic [IDLE_W-1:0]   w_idle_cnt_nxt;
  logic [WK_W-1:0]     r_wake_cnt;
  logic [WK_W-1:0]     w_wake_cnt_nxt;
  logic                w_gate_inc;
  logic                w_idle;
  logic                r_clk_enable;
  logic                r_ready;
  logic                r_gated;
  logic [STAT_W-1:0]   r_gate_cnt;

  assign w_idle = !busy_i && !wake_req_i && !force_on_i;

  always_comb begin
    w_state_nxt    = r_state;
    w_idle_cnt_nxt = r_idle_cnt;
    w_wake_cnt_nxt = r_wake_cnt;
    w_gate_inc     = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (!w_idle || idle_thresh_i == '0) begin
          w_idle_cnt_nxt = '0;
        end else if (r_idle_cnt >= idle_thresh_i - IDLE_W'(1)) begin
          // >= so a threshold lowered mid-count gates on the next idle cycle
          w_state_nxt    = ST_GATED;
          w_idle_cnt_nxt = '0;
          w_gate_inc     = 1'b1;
        end else begin
          w_idle_cnt_nxt = r_idle_cnt + IDLE_W'(1);
        end
      end
      ST_GATED: begin
        if (!w_idle) begin
          w_wake_cnt_nxt = '0;
          w_state_nxt    = (WAKE_LAT == 0) ? ST_RUN : ST_WAKE;
        end
      end
      ST_WAKE: begin
        // Wake always runs to completion; activity here is irrelevant.
        w_idle_cnt_nxt = '0;
        w_wake_cnt_nxt = r_wake_cnt + WK_W'(1);
        if (r_wake_cnt == WAKE_LAST) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt    = ST_RUN;
        w_idle_cnt_nxt = '0;
        w_wake_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= ST_RUN;
      r_idle_cnt   <= '0;
      r_wake_cnt   <= '0;
      r_gate_cnt   <= '0;
      r_clk_enable <= 1'b1;
      r_ready      <= 1'b1;
      r_gated      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idle_cnt   <= w_idle_cnt_nxt;
      r_wake_cnt   <= w_wake_cnt_nxt;
      r_gate_cnt   <= r_gate_cnt + STAT_W'(w_gate_inc);
      r_clk_enable <= (w_state_nxt != ST_GATED);
      r_ready      <= (w_state_nxt == ST_RUN);
      r_gated      <= (w_state_nxt == ST_GATED);
    end
  end

  // Scan must always be able to clock the domain, whatever the FSM is doing.
  assign clk_senable_o = scan_en_i;
  assign clk_enable_o  = r_clk_enable;
  assign ready_o       = r_ready;
  assign gated_o       = r_gated;
  assign gate_cnt_o    = r_gate_cnt;

endmodule

// File: tb/tb_rrv64_clkgate_ctrl.sv
// Directed plus randomized bench for rrv64_clkgate_ctrl, two instances (WAKE_LAT 2/STAT_W 16 and WAKE_LAT 3/STAT_W 4).
module tb_rrv64_clkgate_ctrl;

  logic       clk;
  logic       rst;
  logic       busy;
  logic       wake_req;
  logic       force_on;
  logic [7:0] thresh;
  logic       scan_en;

  logic        a_en, a_sen, a_rdy, a_gated;
  logic [15:0] a_cnt;
  logic        b_en, b_sen, b_rdy, b_gated;
  logic [3:0]  b_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state, index 0 = dut_a, 1 = dut_b
  int lat [2] = '{2, 3};
  int cnt_mod [2] = '{65536, 16};
  bit m_gated [2];
  int m_wake_left [2];
  int m_idle_run [2];
  int m_gates [2];

  rrv64_clkgate_ctrl #(.IDLE_W(8), .WAKE_LAT(2), .STAT_W(16)) dut_a (
    .clk_i(clk), .rst_i(rst), .busy_i(busy), .wake_req_i(wake_req),
    .force_on_i(force_on), .idle_thresh_i(thresh), .scan_en_i(scan_en),
    .clk_enable_o(a_en), .clk_senable_o(a_sen), .ready_o(a_rdy),
    .gated_o(a_gated), .gate_cnt_o(a_cnt)
  );

  rrv64_clkgate_ctrl #(.IDLE_W(8), .WAKE_LAT(3), .STAT_W(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .busy_i(busy), .wake_req_i(wake_req),
    .force_on_i(force_on), .idle_thresh_i(thresh), .scan_en_i(scan_en),
    .clk_enable_o(b_en), .clk_senable_o(b_sen), .ready_o(b_rdy),
    .gated_o(b_gated), .gate_cnt_o(b_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_tick();
    bit idle;
    idle = !busy && !wake_req && !force_on;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_gated[k] = 0; m_wake_left[k] = 0; m_idle_run[k] = 0; m_gates[k] = 0;
      end else if (m_gated[k]) begin
        if (!idle) begin
          m_gated[k] = 0;
          m_wake_left[k] = lat[k];
        end
      end else if (m_wake_left[k] > 0) begin
        m_wake_left[k]--;
      end else if (idle && thresh != 0) begin
        m_idle_run[k]++;
        if (m_idle_run[k] >= int'(thresh)) begin
          m_gated[k] = 1;
          m_gates[k]++;
          m_idle_run[k] = 0;
        end
      end else begin
        m_idle_run[k] = 0;
      end
    end
  endtask

  // One clock: check the combinational scan path, advance, then check registered outputs.
  task automatic step();
    #1;
    chk("senable_a", 32'(a_sen), 32'(scan_en));
    chk("senable_b", 32'(b_sen), 32'(scan_en));
    @(posedge clk);
    model_tick();
    #1;
    chk("enable_a", 32'(a_en), 32'(!m_gated[0]));
    chk("ready_a",  32'(a_rdy), 32'(!m_gated[0] && m_wake_left[0] == 0));
    chk("gated_a",  32'(a_gated), 32'(m_gated[0]));
    chk("gatecnt_a", 32'(a_cnt), 32'(m_gates[0] % cnt_mod[0]));
    chk("enable_b", 32'(b_en), 32'(!m_gated[1]));
    chk("ready_b",  32'(b_rdy), 32'(!m_gated[1] && m_wake_left[1] == 0));
    chk("gated_b",  32'(b_gated), 32'(m_gated[1]));
    chk("gatecnt_b", 32'(b_cnt), 32'(m_gates[1] % cnt_mod[1]));
  endtask

  task automatic idle_inputs();
    busy = 0; wake_req = 0; force_on = 0;
  endtask

  initial begin
    rst = 1; idle_inputs(); thresh = 8'd4; scan_en = 0;
    step();
    step();
    rst = 0;
    chk("reset_enable", 32'(a_en), 32'd1);
    chk("reset_ready", 32'(a_rdy), 32'd1);

    // Gate after 4 idle cycles
    for (int i = 1; i <= 6; i++) begin
      step();
      if (i == 3) chk("still_on_after_3", 32'(a_en), 32'd1);
      if (i == 4) chk("gated_after_4", 32'(a_en), 32'd0);
    end
    chk("gated_status", 32'(a_gated), 32'd1);
    chk("gate_cnt_one", 32'(a_cnt), 32'd1);

    // Scan enable while gated
    scan_en = 1;
    #1 chk("scan_same_cycle", 32'(b_sen), 32'd1);
    step(); step();
    chk("scan_keeps_gated", 32'(a_en), 32'd0);
    scan_en = 0;

    // One-cycle wake pulse, WAKE_LAT=2 on dut_a
    wake_req = 1;
    step();
    wake_req = 0;
    chk("wake_enable_next", 32'(a_en), 32'd1);
    chk("wake_ready_lo0", 32'(a_rdy), 32'd0);
    step();
    chk("wake_ready_lo1", 32'(a_rdy), 32'd0);
    step();
    chk("wake_ready_hi", 32'(a_rdy), 32'd1);
    for (int i = 0; i < 8; i++) step();

    // Busy every 3rd cycle never lets the count reach 4
    rst = 1; step(); rst = 0;
    for (int i = 0; i < 30; i++) begin
      busy = (i % 3 == 2);
      step();
    end
    idle_inputs();
    chk("busy_no_gate", 32'(a_cnt), 32'd0);

    // Gating disabled, then forced on
    thresh = 0;
    for (int i = 0; i < 100; i++) step();
    chk("thresh0_on", 32'(a_en), 32'd1);
    thresh = 4; force_on = 1;
    for (int i = 0; i < 100; i++) step();
    chk("force_on", 32'(a_gated), 32'd0);
    force_on = 0;

    // Reset one cycle into WAKE
    rst = 1; step(); rst = 0;
    for (int i = 0; i < 4; i++) step();
    wake_req = 1; step(); wake_req = 0;
    step();
    rst = 1; step(); rst = 0;
    chk("rst_wake_ready", 32'(b_rdy), 32'd1);
    chk("rst_wake_enable", 32'(b_en), 32'd1);
    chk("rst_wake_cnt", 32'(b_cnt), 32'd0);

    // 16 gating events wrap the 4-bit counter
    thresh = 1;
    for (int i = 0; i < 16; i++) begin
      busy = 0; step();
      busy = 1;
      for (int j = 0; j < 4; j++) step();
    end
    busy = 0;
    chk("wrap_b", 32'(b_cnt), 32'd0);
    chk("nowrap_a", 32'(a_cnt), 32'd16);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 299) == 0);
      busy     = ($urandom_range(0, 5) == 0);
      wake_req = ($urandom_range(0, 15) == 0);
      force_on = ($urandom_range(0, 40) == 0);
      scan_en  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 20) == 0) thresh = 8'($urandom_range(0, 6));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
